// File: rtl/fb_loader.sv
// fb_loader: writes a valid/ready stream of 12-bit RGB pixels into the
// display's R/G/B pixel memories in raster order. A frame load begins only
// after a vsync falling edge, so a new image never starts mid-scan.
module fb_loader #(
  parameter int IMG_W = 240,
  parameter int IMG_H = 180,
  parameter int AW    = 16,
  parameter int CW    = 4
) (
  input  logic          dclk,
  input  logic          clr_n,
  input  logic          vsync,
  input  logic          start,
  input  logic          s_valid,
  input  logic [3*CW-1:0] s_data,
  input  logic          s_sof,
  output logic          s_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [CW-1:0] wr_r,
  output logic [CW-1:0] wr_g,
  output logic [CW-1:0] wr_b,
  output logic          busy,
  output logic          done,
  output logic          err_sync
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_vs;
  logic          r_hunting;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;

  logic          w_vs_fall;
  logic          w_acc;
  logic          w_restart;
  logic          w_wr;
  logic          w_final;
  logic [XW-1:0] w_cur_x;
  logic [YW-1:0] w_cur_y;
  logic [AW-1:0] w_cur_addr;

  // vs_fall compares the previous vsync sample with the current level
  assign w_vs_fall = r_vs & ~vsync;

  // Every beat in LOAD is accepted; a sof beat always writes (restart or
  // end of hunting), other beats write only once hunting is over.
  assign w_acc     = s_valid & (r_state == ST_LOAD);
  assign w_restart = w_acc & s_sof;
  assign w_wr      = w_acc & (s_sof | ~r_hunting);

  // A sof beat lands on pixel (0,0) regardless of the running counters
  assign w_cur_x    = w_restart ? '0 : r_x;
  assign w_cur_y    = w_restart ? '0 : r_y;
  assign w_cur_addr = w_restart ? '0 : r_addr;
  assign w_final    = w_wr & (w_cur_x == X_LAST) & (w_cur_y == Y_LAST);

  assign s_ready = (r_state == ST_LOAD);
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);

  // Next-state decision for the load sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start)     w_state_nxt = ST_WAIT_VS;
      ST_WAIT_VS: if (w_vs_fall) w_state_nxt = ST_LOAD;
      ST_LOAD:    if (w_final)   w_state_nxt = ST_DONE;
      ST_DONE:                   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge dclk) begin
    if (!clr_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // vsync history for falling-edge detection
  always_ff @(posedge dclk) begin
    if (!clr_n) r_vs <= 1'b0;
    else        r_vs <= vsync;
  end

  // Raster position and running address; advanced from the written pixel
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_addr    <= '0;
      r_hunting <= 1'b0;
    end else if ((r_state == ST_WAIT_VS) && w_vs_fall) begin
      r_x       <= '0;
      r_y       <= '0;
      r_addr    <= '0;
      r_hunting <= 1'b1;
    end else if (w_wr) begin
      r_hunting <= 1'b0;
      r_addr    <= w_cur_addr + 1'b1;
      if (w_cur_x == X_LAST) begin
        r_x <= '0;
        r_y <= (w_cur_y == Y_LAST) ? '0 : w_cur_y + 1'b1;
      end else begin
        r_x <= w_cur_x + 1'b1;
        r_y <= w_cur_y;
      end
    end
  end

  // Sticky sync error: set on a sof after the frame was already locked,
  // cleared when the next load is requested
  always_ff @(posedge dclk) begin
    if (!clr_n)                            err_sync <= 1'b0;
    else if ((r_state == ST_IDLE) && start) err_sync <= 1'b0;
    else if (w_restart && !r_hunting)       err_sync <= 1'b1;
  end

  // Registered write port; address and data hold between writes
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_r    <= '0;
      wr_g    <= '0;
      wr_b    <= '0;
    end else begin
      wr_en <= w_wr;
      if (w_wr) begin
        wr_addr <= w_cur_addr;
        wr_r    <= s_data[3*CW-1:2*CW];
        wr_g    <= s_data[2*CW-1:CW];
        wr_b    <= s_data[CW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fb_loader.sv
// Testbench for fb_loader: directed stimulus, a pixel-index model of the
// loader checked every cycle, and literal expectations at key points.
module tb_fb_loader;

  localparam int IMG_W = 240;
  localparam int IMG_H = 180;
  localparam int AW    = 16;
  localparam int CW    = 4;
  localparam int TOTAL = IMG_W * IMG_H;

  logic          dclk = 1'b0;
  logic          clr_n;
  logic          vsync;
  logic          start;
  logic          s_valid;
  logic [11:0]   s_data;
  logic          s_sof;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_r;
  logic [CW-1:0] wr_g;
  logic [CW-1:0] wr_b;
  logic          busy;
  logic          done;
  logic          err_sync;

  always #20 dclk = ~dclk;

  fb_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .CW(CW)) dut (
    .dclk     (dclk),
    .clr_n    (clr_n),
    .vsync    (vsync),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_sof    (s_sof),
    .s_ready  (s_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_r     (wr_r),
    .wr_g     (wr_g),
    .wr_b     (wr_b),
    .busy     (busy),
    .done     (done),
    .err_sync (err_sync)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for vsync, 2 loading, 3 done.
  // The frame is tracked as a pixel index p; its address is simply p.
  int         m_phase = 0;
  int         m_p     = 0;
  bit         m_hunt  = 1'b0;
  bit         m_wen   = 1'b0;
  int         m_waddr = 0;
  logic [11:0] m_wdata = 12'h000;
  bit         m_err   = 1'b0;
  bit         m_vs    = 1'b0;

  always @(posedge dclk) begin
    if (!clr_n) begin
      m_phase = 0;
      m_wen   = 1'b0;
      m_waddr = 0;
      m_wdata = 12'h000;
      m_err   = 1'b0;
      m_vs    = 1'b0;
    end else begin
      m_wen = 1'b0;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_err = 1'b0; end
        1: if (m_vs && !vsync) begin m_phase = 2; m_p = 0; m_hunt = 1'b1; end
        2: if (s_valid) begin
             if (s_sof) begin
               if (!m_hunt) m_err = 1'b1;
               m_hunt = 1'b0;
               m_p    = 0;
             end
             if (!m_hunt) begin
               m_wen   = 1'b1;
               m_waddr = m_p;
               m_wdata = s_data;
               m_p++;
               if (m_p == TOTAL) m_phase = 3;
             end
           end
        default: m_phase = 0;
      endcase
      m_vs = vsync;
    end
  end

  // Observations of the DUT used by the literal checks
  int          n_wr         = 0;
  int          n_done       = 0;
  int          last_wr_addr = -1;
  int          first_addr   = -1;
  logic [11:0] first_data   = 12'hFFF;
  bit          saw_wrap     = 1'b0;

  always @(posedge dclk) begin
    #1;
    chk("s_ready",  32'(s_ready),  32'(m_phase == 2));
    chk("busy",     32'(busy),     32'(m_phase != 0));
    chk("done",     32'(done),     32'(m_phase == 3));
    chk("err_sync", 32'(err_sync), 32'(m_err));
    chk("wr_en",    32'(wr_en),    32'(m_wen));
    chk("wr_addr",  32'(wr_addr),  m_waddr);
    chk("wr_data",  32'({wr_r, wr_g, wr_b}), 32'(m_wdata));
    if (wr_en) begin
      n_wr++;
      if (first_addr < 0) begin
        first_addr = int'(wr_addr);
        first_data = {wr_r, wr_g, wr_b};
      end
      if (wr_addr == 16'd240 && last_wr_addr == 239) saw_wrap = 1'b1;
      last_wr_addr = int'(wr_addr);
    end
    if (done) n_done++;
  end

  initial begin
    int rdy_cnt;
    int w;
    int k;
    int cyc;

    clr_n   = 1'b0;
    start   = 1'b1;
    s_valid = 1'b1;
    vsync   = 1'b1;
    s_sof   = 1'b0;
    s_data  = 12'hABC;

    // Reset held for three cycles with start and s_valid asserted
    repeat (3) @(negedge dclk);
    chk("rst_s_ready",  32'(s_ready),  32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err_sync", 32'(err_sync), 32'd0);
    clr_n   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(negedge dclk);
    chk("idle_busy",   32'(busy), 32'd0);
    chk("idle_writes", n_wr,      32'd0);

    // Vsync gating: stream is offered but nothing is taken before the edge
    start = 1'b1;
    @(negedge dclk);
    start   = 1'b0;
    s_valid = 1'b1;
    s_sof   = 1'b0;
    rdy_cnt = 0;
    n_wr    = 0;
    repeat (100) begin
      @(negedge dclk);
      if (s_ready) rdy_cnt++;
    end
    chk("gate_ready_cycles", rdy_cnt,      32'd0);
    chk("gate_writes",       n_wr,         32'd0);
    chk("gate_busy",         32'(busy),    32'd1);
    vsync = 1'b0;
    @(negedge dclk);
    chk("vs_fall_ready", 32'(s_ready), 32'd1);
    vsync = 1'b1;

    // Hunting: five non-sof beats are discarded
    n_wr       = 0;
    first_addr = -1;
    repeat (5) @(negedge dclk);
    chk("hunt_writes", n_wr, 32'd0);
    s_sof  = 1'b1;
    s_data = 12'h000;
    @(negedge dclk);
    chk("sof_wr_en",   32'(wr_en),   32'd1);
    chk("sof_wr_addr", 32'(wr_addr), 32'd0);
    s_sof = 1'b0;
    for (int a = 1; a < 1000; a++) begin
      s_data = a[11:0];
      @(negedge dclk);
    end
    chk("first_addr", first_addr, 32'd0);
    chk("first_data", 32'(first_data), 32'h000);
    chk("pre_restart_err", 32'(err_sync), 32'd0);
    chk("pre_restart_addr", 32'(wr_addr), 32'd999);

    // Mid-frame sof restarts the frame and flags the error
    s_sof  = 1'b1;
    s_data = 12'h000;
    @(negedge dclk);
    chk("restart_wr_en",   32'(wr_en),    32'd1);
    chk("restart_wr_addr", 32'(wr_addr),  32'd0);
    chk("restart_err",     32'(err_sync), 32'd1);
    s_sof    = 1'b0;
    n_done   = 0;
    saw_wrap = 1'b0;
    for (int a = 1; a < TOTAL; a++) begin
      s_data = a[11:0];
      @(negedge dclk);
    end
    s_valid = 1'b0;
    w = 0;
    while (!done && w < 20) begin
      @(negedge dclk);
      w++;
    end
    chk("frame_done",     32'(done),    32'd1);
    chk("frame_last_wen", 32'(wr_en),   32'd1);
    chk("frame_last_addr", 32'(wr_addr), 32'd43199);
    chk("frame_last_data", 32'({wr_r, wr_g, wr_b}), 32'h8BF);
    @(negedge dclk);
    chk("post_done_busy", 32'(busy),     32'd0);
    chk("post_done_done", 32'(done),     32'd0);
    chk("done_pulses",    n_done,        32'd1);
    chk("row_wrap",       32'(saw_wrap), 32'd1);
    chk("err_sticky",     32'(err_sync), 32'd1);
    chk("frame_writes",   n_wr,          32'd44200);

    // Next start clears the sticky error
    start = 1'b1;
    @(negedge dclk);
    start = 1'b0;
    chk("start_clears_err", 32'(err_sync), 32'd0);
    chk("start_busy",       32'(busy),     32'd1);

    // Backpressure with random gaps, then reset at pixel 500
    vsync = 1'b0;
    @(negedge dclk);
    vsync = 1'b1;
    n_wr  = 0;
    k     = 0;
    cyc   = 0;
    while (k < 500 && cyc < 3000) begin
      s_valid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_sof   = (k == 0);
      s_data  = k[11:0];
      @(negedge dclk);
      if (s_valid) k++;
      cyc++;
    end
    chk("bp_beats", k, 32'd500);
    clr_n   = 1'b0;
    s_valid = 1'b1;
    s_sof   = 1'b0;
    s_data  = 12'h1F4;
    @(negedge dclk);
    chk("mid_rst_wr_en",   32'(wr_en),   32'd0);
    chk("mid_rst_busy",    32'(busy),    32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    clr_n = 1'b1;
    repeat (5) @(negedge dclk);
    chk("bp_writes",      n_wr,         32'd500);
    chk("post_rst_busy",  32'(busy),    32'd0);
    chk("post_rst_wr_en", 32'(wr_en),   32'd0);
    s_valid = 1'b0;
    @(negedge dclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_loader.md
Name: fb_loader

Overview:
- Frame-buffer loader upstream of the 240x180 VGA image display stage.
- Accepts a valid/ready stream of 12-bit RGB pixels and writes them into the display's R/G/B pixel memories in raster order (address = x + y*IMG_W).
- Starts each frame only after a vsync pulse, so a new image never begins mid-scan.
- Lets the game logic replace the displayed image at run time without reloading memory files.

Parameters:
IMG_W, 240, pixels per image row
IMG_H, 180, image rows
AW, 16, write-address width; must satisfy 2^AW >= IMG_W*IMG_H
CW, 4, bits per colour channel

Ports:
dclk  input  1  pixel clock (25 MHz), shared with the display stage
clr_n  input  1  synchronous active-low reset
vsync  input  1  active-low vertical sync from the display stage
start  input  1  request to load one frame; sampled only in IDLE
s_valid  input  1  stream pixel valid
s_data  input  3*CW  pixel {r,g,b}; r in the MSBs
s_sof  input  1  marks the first pixel of a frame
s_ready  output  1  loader can accept a pixel
wr_en  output  1  memory write strobe
wr_addr  output  AW  memory write address
wr_r  output  CW  red write data
wr_g  output  CW  green write data
wr_b  output  CW  blue write data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a frame has been fully written
err_sync  output  1  sticky flag: unexpected s_sof seen mid-frame

Behaviour:
- Reset: synchronous; clr_n=0 sampled on a dclk rising edge.
  - FSM goes to IDLE.
  - All outputs = 0; x, y, wr_addr, vsync history register = 0.
  - Reset mid-LOAD abandons the frame; no further writes occur.
- vsync edge detect: vsync is registered once. vs_fall = previous 1 and current 0.
- IDLE:
  - s_ready=0.
  - start=1 -> WAIT_VS; err_sync cleared.
- WAIT_VS:
  - s_ready=0.
  - vs_fall -> LOAD with x=0, y=0, hunting=1.
- LOAD:
  - s_ready=1, combinationally, for the whole state.
  - A beat is accepted when s_valid && s_ready.
  - While hunting=1, accepted beats with s_sof=0 are consumed and discarded (no write).
  - An accepted beat with s_sof=1 clears hunting and is written at address 0.
  - While hunting=0, an accepted beat with s_sof=1 sets err_sync=1 and restarts the frame: that beat is written at address 0, and x and y restart from 0.
  - Every written beat updates the counters: x increments; at x=IMG_W-1, x wraps to 0 and y increments. The address is kept as a running counter; no multiplier.
  - Acceptance of pixel (IMG_W-1, IMG_H-1), address 43199 by default -> DONE. s_ready drops in the next cycle.
  - Simultaneous s_sof=1 on the final beat: the restart rule has priority, so it is treated as a restart, not completion.
- Write port:
  - Registered, one-cycle latency: a beat accepted at edge N produces wr_en=1 with its address and data during cycle N+1.
  - wr_en=0 otherwise; wr_addr, wr_r, wr_g and wr_b hold their last values.
- DONE:
  - done=1 for exactly one cycle; the final write is also presented in this cycle.
  - Next state IDLE.
- start is ignored outside IDLE.
- vsync edges are ignored outside WAIT_VS.
- busy=1 in WAIT_VS, LOAD and DONE.

Test Plan:
- Reset: hold clr_n=0 for 3 cycles with s_valid=1 and start=1 -> s_ready=0, wr_en=0, busy=0, done=0, err_sync=0. Release -> IDLE, no writes.
- Full frame: start, vsync low pulse, then 43200 back-to-back beats (sof on the first, s_data=addr[11:0]).
  - First write addr 0, data 0x000, one cycle after acceptance.
  - Addr 239 followed by addr 240 at the row wrap.
  - Last write addr 43199.
  - done pulses once; busy falls the next cycle.
- Vsync gating: start, then 100 cycles of s_valid=1 with vsync=1 -> s_ready=0, no writes. After the vsync falling edge -> s_ready=1.
- Hunting: in LOAD, send 5 beats with sof=0, then a sof beat -> first 5 produce no wr_en; the sof beat writes addr 0.
- Mid-frame sof: after 1000 written pixels, a beat with sof=1 -> err_sync=1, that beat writes addr 0, frame completes 43200 beats later. The next start clears err_sync.
- Backpressure and reset mid-load: toggle s_valid randomly -> addresses stay contiguous with no gaps. Assert clr_n=0 at pixel 500 -> no wr_en after the reset edge, FSM in IDLE.
